// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_NREGS = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  // At least one address bit, even for a two-entry file.
  function automatic int addr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback facing bus of the register file.
interface regfile_mp_if #(
  parameter int XLEN  = regfile_pkg::DEFAULT_XLEN,
  parameter int NREGS = regfile_pkg::DEFAULT_NREGS,
  parameter int NRD   = 2,
  parameter int AW    = regfile_pkg::addr_w(NREGS)
);
  logic                ready;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                wr_drop;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    input  ready, rd_data, wr_drop
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    output ready, rd_data, wr_drop
  );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: walks every entry once, then hands the write
// port over to writeback and raises ready.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_w(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  output logic          ready_o,
  output logic          wr_drop_o,
  output logic          we_o,
  output logic [AW-1:0] waddr_o,
  output logic          clr_sel_o
);

  localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_e     state_q;
  logic [AW-1:0] clr_idx_q;
  logic          ready_q;
  logic          wr_drop_q;
  logic          writable;

  assign writable = ({1'b0, wr_addr_i} < NREGS_W) &&
                    !((ZERO_REG != 0) && (wr_addr_i == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          wr_drop_q <= wr_en_i;
          if (clr_idx_q == LAST_IDX) begin
            state_q   <= READY;
            ready_q   <= 1'b1;
            clr_idx_q <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        READY: begin
          wr_drop_q <= 1'b0;
        end
        default: begin
          state_q <= CLEAR;
        end
      endcase
    end
  end

  // Clear path owns the write port until READY; reset suppresses both paths.
  always_comb begin
    clr_sel_o = (state_q == CLEAR);
    we_o      = 1'b0;
    waddr_o   = wr_addr_i;
    if (!rst) begin
      we_o = clr_sel_o || (ready_q && wr_en_i && writable);
    end
    if (clr_sel_o) begin
      waddr_o = clr_idx_q;
    end
  end

  assign ready_o   = ready_q;
  assign wr_drop_o = wr_drop_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with zero register, optional
// write-to-read bypass and a sequential post-reset clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEFAULT_XLEN,
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int          AW      = addr_w(NREGS);
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [XLEN-1:0]     mem_q [NREGS];
  logic                ready;
  logic                wr_drop;
  logic                we;
  logic [AW-1:0]       waddr;
  logic                clr_sel;
  logic [XLEN-1:0]     wdata;
  logic [AW-1:0]       ra;
  logic [NRD*XLEN-1:0] rd_data_d;

  regfile_clear_fsm #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_clear_fsm (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .ready_o   (ready),
    .wr_drop_o (wr_drop),
    .we_o      (we),
    .waddr_o   (waddr),
    .clr_sel_o (clr_sel)
  );

  assign wdata = clr_sel ? '0 : bus.wr_data;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Address checks come first, so a bypass match implies a writable entry.
  always_comb begin
    rd_data_d = '0;
    ra        = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = bus.rd_addr[i*AW +: AW];
      if (!ready || ({1'b0, ra} >= NREGS_W)) begin
        rd_data_d[i*XLEN +: XLEN] = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_data_d[i*XLEN +: XLEN] = '0;
      end else if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == ra)) begin
        rd_data_d[i*XLEN +: XLEN] = bus.wr_data;
      end else begin
        rd_data_d[i*XLEN +: XLEN] = mem_q[ra];
      end
    end
  end

  assign bus.rd_data = rd_data_d;
  assign bus.ready   = ready;
  assign bus.wr_drop = wr_drop;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the single-cycle RISC-V datapath, replacing the fixed 32x32 two-read-port bank. It generalises width, depth and read-port count, adds a hardwired zero register and optional write-to-read bypass, and performs a sequential post-reset clear, one entry per cycle, with a ready handshake. It sits between decode (read addresses) and writeback (write port).

## Interface
- XLEN, default 32: data width in bits.
- NREGS, default 32: number of entries, at least 2. Need not be a power of two.
- NRD, default 2: number of read ports, at least 1.
- ZERO_REG, default 1: when 1, entry 0 always reads 0 and writes to it are discarded.
- BYPASS, default 1: when 1, a same-cycle write is forwarded to matching read ports.
- AW, derived as clog2(NREGS): address width.
- clk, input, 1: the only clock. All state updates occur on its rising edge.
- rst, input, 1: reset, synchronous and active-high.
- ready, output, 1: clear sequence is complete and the file is usable.
- wr_en, input, 1: write request.
- wr_addr, input, AW: write address.
- wr_data, input, XLEN: write data.
- rd_addr, input, NRD*AW: read addresses. Port i occupies bits [i*AW +: AW].
- rd_data, output, NRD*XLEN: read data. Port i occupies bits [i*XLEN +: XLEN].
- wr_drop, output, 1: registered pulse indicating that a write was discarded.

## Operation
- States are CLEAR and READY.
- **Reset**
  - rst sampled high: state becomes CLEAR, clr_idx becomes 0, ready becomes 0, wr_drop becomes 0.
  - While rst is held high, the block stays in CLEAR with clr_idx = 0.
- **CLEAR state**
  - Each edge with rst low writes 0 to entry clr_idx, then increments clr_idx.
  - The edge that clears entry NREGS-1 moves the state to READY.
- **READY state**
  - Stays in READY until rst is sampled high.
- **Reads (combinational)**
  - While ready = 0, every rd_data port is 0.
  - Otherwise rd_data[i] is the entry at rd_addr[i], subject to the rules below.
  - If rd_addr[i] >= NREGS, the port reads 0.
  - If ZERO_REG = 1 and rd_addr[i] = 0, the port reads 0.
- **Bypass** (BYPASS = 1): read port i returns wr_data in the same cycle when all of the following hold:
  - ready = 1;
  - wr_en = 1;
  - wr_addr = rd_addr[i];
  - the address is a writable entry.
- With BYPASS = 0, a read returns the old value until the edge after the write.
- **Writes**
  - Take effect on the edge when ready = 1, wr_en = 1 and the address is writable.
  - An address is not writable if it is >= NREGS, or if it is 0 with ZERO_REG = 1. Such writes are silently ignored; wr_drop does not fire.
- **wr_drop**
  - Asserted for one cycle on the edge after any wr_en sampled while ready = 0 and rst = 0.
  - Cleared by rst.
- **Simultaneous events**
  - rst high together with wr_en: reset wins. No write occurs and no drop is flagged.
  - When entry k is both cleared and written, the clear wins. This cannot happen in practice, because writes are refused in CLEAR.

## Timing
- Reset values: ready = 0, wr_drop = 0, rd_data = all zeros (forced by ready = 0).
- ready rises exactly NREGS edges after the first edge at which rst is sampled low.
  - With the defaults this is 32 cycles.
- Reset asserted mid-CLEAR or mid-READY restarts the clear from entry 0 and drops ready on the next edge.
- Read latency is 0 cycles (combinational from rd_addr).
- Write-to-read latency:
  - 0 cycles with BYPASS = 1;
  - 1 edge with BYPASS = 0.
- wr_drop latency is 1 edge after the refused request.
- Initial contents before the first reset are undefined.
- Simulation-only preloads for testing are allowed, but are overwritten by the clear.

## Structure
- Shared package regfile_pkg contains:
  - the state enum {CLEAR, READY};
  - the address-width helper function;
  - the default XLEN and NREGS constants.
- Sub-module regfile_clear_fsm contains the state register, the clr_idx counter, ready, and the write-mux select between the clear path and the writeback path.
- The storage array, read muxes and bypass compare live in regfile_mp.

## Test plan
- **Reset clear:** preload entry 5 = 0x5, then pulse rst for 1 cycle.
  - ready = 0 for 32 cycles and rises on the 32nd edge.
  - Reading address 5 then returns 0x0.
- **Write/read with bypass:** write 0xDEADBEEF to address 7 while rd_addr[0] = 7.
  - rd_data[0] = 0xDEADBEEF in the same cycle.
  - Repeat with BYPASS = 0: the old value is returned until the next edge.
- **Zero register and out-of-range:**
  - Write 0x1234 to address 0: it reads 0, and wr_drop stays 0.
  - With NREGS = 24, writing address 30 is ignored and reading address 30 returns 0.
- **Write during CLEAR:** wr_en = 1 to address 3 while ready = 0.
  - wr_drop pulses for exactly 1 cycle.
  - Address 3 reads 0 after ready.
- **Reset mid-clear:** assert rst at clr_idx = 10.
  - ready rises 32 edges after rst is released.
  - All entries read 0.
- **Multi-port:** with NRD = 4 and XLEN = 64, write distinct values to addresses 1-4, then read all four ports simultaneously.
  - Each port returns its own value.
